// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation encoding.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'b000,
    SHL   = 3'b001,
    SHR   = 3'b010,
    ROL   = 3'b011,
    ROR   = 3'b100,
    LOAD  = 3'b101,
    CLEAR = 3'b110,
    RSVD  = 3'b111
  } mode_e;

endpackage

// File: rtl/shift_pattern_match.sv
// Masked pattern comparator gated by full, with a saturating rising-edge counter.
module shift_pattern_match #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DEPTH*WIDTH-1:0]   par_i,
  input  logic [DEPTH*WIDTH-1:0]   pattern_i,
  input  logic [DEPTH*WIDTH-1:0]   mask_i,
  input  logic                     full_i,
  input  logic                     clear_i,
  output logic                     match_o,
  output logic [CNT_W-1:0]         match_cnt_o
);

  logic             prev_match_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign match_o     = full_i && (((par_i ^ pattern_i) & mask_i) == '0);
  assign match_cnt_o = cnt_q;

  // A clear in the same cycle as a rising edge wins over the increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (match_o && !prev_match_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_match_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      prev_match_q <= match_o;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_register_univ.sv
// Parametrised universal shift register with fill tracking and masked pattern trigger.
module shift_register_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   mode,
  input  logic [WIDTH-1:0]             ser_in,
  input  logic [DEPTH*WIDTH-1:0]       par_in,
  input  logic [DEPTH*WIDTH-1:0]       pattern,
  input  logic [DEPTH*WIDTH-1:0]       pat_mask,
  output logic [DEPTH*WIDTH-1:0]       par_out,
  output logic [WIDTH-1:0]             ser_out_hi,
  output logic [WIDTH-1:0]             ser_out_lo,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         full,
  output logic                         match,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int FW = $clog2(DEPTH+1);
  localparam int DW = DEPTH * WIDTH;

  logic [DW-1:0] stages_q, stages_d;
  logic [FW-1:0] fill_q, fill_d, fill_inc;
  mode_e         op;
  logic          clear_op;

  assign op       = mode_e'(mode);
  assign clear_op = en && (op == CLEAR);
  // Stage 0 sits in the low word, so a left shift is a move toward the MSBs.
  assign fill_inc = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + FW'(1);

  always_comb begin
    stages_d = stages_q;
    fill_d   = fill_q;
    if (en) begin
      case (op)
        SHL: begin
          stages_d = {stages_q[DW-WIDTH-1:0], ser_in};
          fill_d   = fill_inc;
        end
        SHR: begin
          stages_d = {ser_in, stages_q[DW-1:WIDTH]};
          fill_d   = fill_inc;
        end
        ROL:   stages_d = {stages_q[DW-WIDTH-1:0], stages_q[DW-1 -: WIDTH]};
        ROR:   stages_d = {stages_q[WIDTH-1:0], stages_q[DW-1:WIDTH]};
        LOAD: begin
          stages_d = par_in;
          fill_d   = FW'(DEPTH);
        end
        CLEAR: begin
          stages_d = '0;
          fill_d   = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages_q <= '0;
      fill_q   <= '0;
    end else begin
      stages_q <= stages_d;
      fill_q   <= fill_d;
    end
  end

  assign par_out    = stages_q;
  assign ser_out_hi = stages_q[DW-1 -: WIDTH];
  assign ser_out_lo = stages_q[WIDTH-1:0];
  assign fill       = fill_q;
  assign full       = (fill_q == FW'(DEPTH));

  shift_pattern_match #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_match (
    .clk         (clk),
    .rst         (rst),
    .par_i       (stages_q),
    .pattern_i   (pattern),
    .mask_i      (pat_mask),
    .full_i      (full),
    .clear_i     (clear_op),
    .match_o     (match),
    .match_cnt_o (match_cnt)
  );

endmodule

// File: tb/tb_shift_register_univ.sv
// Bench for shift_register_univ: directed table, corner sequences and random run vs an array model.
module tb_shift_register_univ;

  localparam int W     = 4;
  localparam int D     = 4;
  localparam int CW    = 8;
  localparam int DW    = W * D;
  localparam int FW    = $clog2(D+1);
  localparam int CMAX  = (1 << CW) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [W-1:0]  ser_in = '0;
  logic [DW-1:0] par_in = '0, pattern = '0, pat_mask = '0;
  logic [DW-1:0] par_out;
  logic [W-1:0]  ser_out_hi, ser_out_lo;
  logic [FW-1:0] fill;
  logic          full, match;
  logic [CW-1:0] match_cnt;

  always #5 clk = ~clk;

  shift_register_univ #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .ser_in(ser_in),
    .par_in(par_in), .pattern(pattern), .pat_mask(pat_mask),
    .par_out(par_out), .ser_out_hi(ser_out_hi), .ser_out_lo(ser_out_lo),
    .fill(fill), .full(full), .match(match), .match_cnt(match_cnt)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [W-1:0] stg[D];
  int           m_fill;
  int           m_cnt;
  bit           m_prev;

  function automatic logic [DW-1:0] m_pack();
    logic [DW-1:0] v = '0;
    for (int k = 0; k < D; k++) v[k*W +: W] = stg[k];
    return v;
  endfunction

  function automatic bit m_match();
    return (m_fill == D) && (((m_pack() ^ pattern) & pat_mask) == '0);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < D; k++) stg[k] = '0;
    m_fill = 0;
    m_cnt  = 0;
    m_prev = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic m_edge();
    logic [W-1:0] old[D];
    bit cur;
    cur = m_match();
    if (en && mode == 3'b110) m_cnt = 0;
    else if (cur && !m_prev && m_cnt < CMAX) m_cnt++;
    m_prev = cur;
    for (int k = 0; k < D; k++) old[k] = stg[k];
    if (en) begin
      case (mode)
        3'b001: begin
          for (int k = 1; k < D; k++) stg[k] = old[k-1];
          stg[0] = ser_in;
          if (m_fill < D) m_fill++;
        end
        3'b010: begin
          for (int k = 0; k < D-1; k++) stg[k] = old[k+1];
          stg[D-1] = ser_in;
          if (m_fill < D) m_fill++;
        end
        3'b011: for (int k = 0; k < D; k++) stg[k] = old[(k+D-1) % D];
        3'b100: for (int k = 0; k < D; k++) stg[k] = old[(k+1) % D];
        3'b101: begin
          for (int k = 0; k < D; k++) stg[k] = par_in[k*W +: W];
          m_fill = D;
        end
        3'b110: begin
          for (int k = 0; k < D; k++) stg[k] = '0;
          m_fill = 0;
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    cmp({tag, " par_out"},    32'(par_out),    32'(m_pack()));
    cmp({tag, " fill"},       32'(fill),       32'(m_fill));
    cmp({tag, " full"},       32'(full),       32'(m_fill == D));
    cmp({tag, " match"},      32'(match),      32'(m_match()));
    cmp({tag, " match_cnt"},  32'(match_cnt),  32'(m_cnt));
    cmp({tag, " ser_out_hi"}, 32'(ser_out_hi), 32'(stg[D-1]));
    cmp({tag, " ser_out_lo"}, 32'(ser_out_lo), 32'(stg[0]));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic e, input logic [2:0] m, input logic [W-1:0] s,
                      input logic [DW-1:0] p, input logic [DW-1:0] pt, input logic [DW-1:0] mk);
    en = e; mode = m; ser_in = s; par_in = p; pattern = pt; pat_mask = mk;
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          en;
    logic [2:0]    mode;
    logic [W-1:0]  ser;
    logic [DW-1:0] par;
    logic [DW-1:0] pat;
    logic [DW-1:0] mask;
    logic [DW-1:0] exp_par;
    int            exp_fill;
    logic          exp_match;
    int            exp_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, input logic [2:0] m, input logic [W-1:0] s,
                     input logic [DW-1:0] p, input logic [DW-1:0] pt, input logic [DW-1:0] mk,
                     input logic [DW-1:0] xp, input int xf, input logic xm, input int xc);
    vec_t v;
    v.en = e; v.mode = m; v.ser = s; v.par = p; v.pat = pt; v.mask = mk;
    v.exp_par = xp; v.exp_fill = xf; v.exp_match = xm; v.exp_cnt = xc;
    tbl.push_back(v);
  endtask

  initial begin
    // shift-in, unmasked so match follows full
    add(1, 3'b001, 4'h1, 0, 0, 0,          16'h0001, 1, 0, 0);
    add(1, 3'b001, 4'h2, 0, 0, 0,          16'h0012, 2, 0, 0);
    add(1, 3'b001, 4'h3, 0, 0, 0,          16'h0123, 3, 0, 0);
    add(1, 3'b001, 4'h4, 0, 0, 0,          16'h1234, 4, 1, 0);
    // rotate
    add(1, 3'b101, 0, 16'h1234, 0, 0,      16'h1234, 4, 1, 1);
    add(1, 3'b100, 0, 0, 0, 0,             16'h4123, 4, 1, 1);
    add(1, 3'b011, 0, 0, 0, 0,             16'h1234, 4, 1, 1);
    add(1, 3'b011, 0, 0, 0, 0,             16'h2341, 4, 1, 1);
    // masked match
    add(1, 3'b110, 0, 0, 0, 0,             16'h0000, 0, 0, 0);
    add(1, 3'b101, 0, 16'h1234, 16'h12F4, 16'hFF0F, 16'h1234, 4, 1, 0);
    add(1, 3'b000, 0, 0, 16'h12F4, 16'hFF0F, 16'h1234, 4, 1, 1);
    add(1, 3'b000, 0, 0, 16'h12F4, 16'hFF0F, 16'h1234, 4, 1, 1);
    add(1, 3'b000, 0, 0, 16'h12F4, 16'hFF0F, 16'h1234, 4, 1, 1);
    add(1, 3'b010, 0, 0, 16'h12F4, 16'hFF0F, 16'h0123, 4, 0, 1);
    add(1, 3'b101, 0, 16'h1234, 16'h12F4, 16'hFF0F, 16'h1234, 4, 1, 1);
    add(1, 3'b000, 0, 0, 16'h12F4, 16'hFF0F, 16'h1234, 4, 1, 2);
    // fill gating
    add(1, 3'b110, 0, 0, 0, 16'hFFFF,      16'h0000, 0, 0, 0);
    add(1, 3'b001, 0, 0, 0, 16'hFFFF,      16'h0000, 1, 0, 0);
    add(1, 3'b001, 0, 0, 0, 16'hFFFF,      16'h0000, 2, 0, 0);
    add(1, 3'b001, 0, 0, 0, 16'hFFFF,      16'h0000, 3, 0, 0);
    add(1, 3'b001, 0, 0, 0, 16'hFFFF,      16'h0000, 4, 1, 0);
    add(1, 3'b001, 0, 0, 0, 16'hFFFF,      16'h0000, 4, 1, 1);
    add(1, 3'b001, 0, 0, 0, 16'hFFFF,      16'h0000, 4, 1, 1);
    // enable low and reserved mode
    add(0, 3'b001, 4'hF, 0, 0, 16'hFFFF,   16'h0000, 4, 1, 1);
    add(0, 3'b001, 4'hF, 0, 0, 16'hFFFF,   16'h0000, 4, 1, 1);
    add(0, 3'b001, 4'hF, 0, 0, 16'hFFFF,   16'h0000, 4, 1, 1);
    add(1, 3'b111, 4'hF, 16'hFFFF, 0, 16'hFFFF, 16'h0000, 4, 1, 1);

    do_reset();
    cmp("reset par_out", 32'(par_out), 32'h0);
    cmp("reset fill", 32'(fill), 32'h0);
    cmp("reset match_cnt", 32'(match_cnt), 32'h0);
    cmp("reset match", 32'(match), 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].mode, tbl[i].ser, tbl[i].par, tbl[i].pat, tbl[i].mask);
      cmp($sformatf("tbl%0d par_out", i), 32'(par_out), 32'(tbl[i].exp_par));
      cmp($sformatf("tbl%0d fill", i), 32'(fill), 32'(tbl[i].exp_fill));
      cmp($sformatf("tbl%0d match", i), 32'(match), 32'(tbl[i].exp_match));
      cmp($sformatf("tbl%0d match_cnt", i), 32'(match_cnt), 32'(tbl[i].exp_cnt));
      check_model($sformatf("tbl%0d model", i));
    end

    // async reset between edges
    step(1, 3'b101, 0, 16'hABCD, 0, 0);
    cmp("pre-rst par_out", 32'(par_out), 32'hABCD);
    #2 rst = 1'b1;
    #1;
    m_reset();
    cmp("async rst par_out", 32'(par_out), 32'h0);
    cmp("async rst fill", 32'(fill), 32'h0);
    cmp("async rst match_cnt", 32'(match_cnt), 32'h0);
    cmp("async rst full", 32'(full), 32'h0);
    #2 rst = 1'b0;
    step(1, 3'b001, 4'hF, 0, 0, 16'hFFFF);
    cmp("post-rst par_out", 32'(par_out), 32'h000F);
    cmp("post-rst fill", 32'(fill), 32'h1);

    // counter saturation: alternate matching / non-matching loads
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1, 3'b101, 0, 16'h1234, 16'h1234, 16'hFFFF);
      check_model("sat hit");
      step(1, 3'b101, 0, 16'h0000, 16'h1234, 16'hFFFF);
      check_model("sat miss");
    end
    cmp("saturated match_cnt", 32'(match_cnt), 32'(CMAX));
    step(1, 3'b110, 0, 0, 16'h1234, 16'hFFFF);
    cmp("clear after sat", 32'(match_cnt), 32'h0);

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] pt, mk;
      pt = ($urandom_range(0, 1) == 1) ? m_pack() : DW'($urandom);
      case ($urandom_range(0, 3))
        0:       mk = '0;
        1:       mk = '1;
        default: mk = DW'($urandom) & DW'($urandom);
      endcase
      step(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), W'($urandom),
           DW'($urandom), pt, mk);
      check_model($sformatf("rnd%0d", i));
      // same-cycle response to a pattern/mask change
      pattern  = DW'($urandom);
      pat_mask = ($urandom_range(0, 1) == 1) ? '0 : DW'($urandom);
      #1;
      cmp($sformatf("rnd%0d comb match", i), 32'(match), 32'(m_match()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_register_univ.md
Name: shift_register_univ

Overview:
- Parametrised universal shift register. Successor to the fixed 4-bit shift register.
- Holds DEPTH stages of WIDTH bits each.
- Supports hold, left/right shift, left/right rotate, parallel load and clear.
- Tracks how many stages are filled and detects a programmable masked pattern, for use as a stream-capture/trigger block in front of datapath logic.

Parameters:
- WIDTH, 4, bits per stage.
- DEPTH, 4, number of stages (>=2).
- CNT_W, 8, width of the saturating match-event counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  update enable; 0 forces hold regardless of mode.
- mode  in  3  operation select (see Behaviour).
- ser_in  in  WIDTH  word shifted in by SHL/SHR.
- par_in  in  DEPTH*WIDTH  parallel load data; stage k = par_in[k*WIDTH +: WIDTH].
- pattern  in  DEPTH*WIDTH  compare pattern, same packing.
- pat_mask  in  DEPTH*WIDTH  per-bit compare enable (1 = compare).
- par_out  out  DEPTH*WIDTH  registered stage contents, same packing.
- ser_out_hi  out  WIDTH  stage DEPTH-1 (word leaving on SHL).
- ser_out_lo  out  WIDTH  stage 0 (word leaving on SHR).
- fill  out  $clog2(DEPTH+1)  valid-stage count.
- full  out  1  fill == DEPTH.
- match  out  1  masked pattern hit.
- match_cnt  out  CNT_W  count of match rising edges, saturating.

Behaviour:
- Reset (async, immediate on rst=1): all stages 0, fill 0, full 0, match 0, match_cnt 0. Reset asserted mid-operation clears state within the same cycle. First update occurs on the first clk edge after rst deasserts.
- Mode encoding, applied on the clk edge when en=1:
  - 000 HOLD: no change.
  - 001 SHL: stage[k] <= stage[k-1]; stage[0] <= ser_in.
  - 010 SHR: stage[k] <= stage[k+1]; stage[DEPTH-1] <= ser_in.
  - 011 ROL: SHL with stage[0] <= stage[DEPTH-1].
  - 100 ROR: SHR with stage[DEPTH-1] <= stage[0].
  - 101 LOAD: stages <= par_in.
  - 110 CLEAR: stages <= 0.
  - 111 reserved: treated as HOLD.
- Latency: one cycle from mode/data to par_out. ser_out_hi and ser_out_lo are combinational taps of the stage registers.
- fill:
  - CLEAR -> 0.
  - LOAD -> DEPTH.
  - SHL/SHR -> min(fill+1, DEPTH); saturates, never wraps.
  - HOLD, rotates, reserved and en=0 -> unchanged.
- full is combinational from fill.
- match is combinational: full && (((par_out ^ pattern) & pat_mask) == 0).
  - Suppressed while fill < DEPTH, even if the bits compare equal.
  - Reflects pattern/pat_mask changes in the same cycle.
- match_cnt:
  - Increments on each clk edge where match=1 and the previous registered match was 0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst and CLEAR mode. CLEAR takes priority over an increment in the same cycle.
- pat_mask all zero: match == full.

Decomposition:
- Package shift_reg_pkg: mode_e enum (HOLD, SHL, SHR, ROL, ROR, LOAD, CLEAR, RSVD) as 3-bit logic.
- Top module: stage array, fill and mode decode.
- One sub-module, shift_pattern_match, parametrised by WIDTH/DEPTH/CNT_W. It takes par_out/pattern/pat_mask/full and produces match, a registered previous-match flop and match_cnt.

Test Plan (WIDTH=4, DEPTH=4):
- Shift-in: reset, then SHL with ser_in 1,2,3,4 on four edges -> par_out 0x1234; fill 1,2,3,4; full=1 after the 4th edge; ser_out_hi=1, ser_out_lo=4.
- Rotate: LOAD 0x1234, then ROR once -> 0x4123; then ROL twice -> 0x2341; fill stays 4.
- Masked match: pattern 0x12F4, pat_mask 0xFF0F, LOAD 0x1234 -> match=1, match_cnt=1. Hold 3 cycles -> match_cnt stays 1. SHR ser_in 0 -> 0x0123, match=0. LOAD 0x1234 again -> match_cnt=2.
- Fill gating: CLEAR with pattern 0, pat_mask 0xFFFF -> match=0 (fill=0). Six SHL of ser_in 0 -> fill 1,2,3,4,4,4; match=1 from the 4th edge; match_cnt=1.
- Hold/enable: en=0 with mode=SHL for 3 edges -> par_out, fill and match_cnt unchanged. en=1, mode=111 -> unchanged.
- Async reset mid-op: LOAD 0xABCD, then assert rst between clock edges -> par_out=0, fill=0, match_cnt=0 immediately. Deassert rst, then SHL ser_in 0xF -> 0x000F.
